// File: rtl/wb_seg_reg_p.sv
// Memory / write-back segment: a byte-writable dual-port data RAM and the
// MEM->WB pipeline register that sits on its read path. Port A serves the
// core's loads and stores and is gated by the segment enable and flush.
// Port B is an always-on debug port.
module wb_seg_reg_p #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4096,
    parameter int RD_W  = 5,
    parameter int RW_W  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            clear,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] WD,
    input  logic [3:0]      WE,
    output logic [XLEN-1:0] RD,
    output logic [1:0]      LoadedBytesSelect,
    output logic            StoreMisalignW,
    input  logic [XLEN-1:0] A2,
    input  logic [XLEN-1:0] WD2,
    input  logic [3:0]      WE2,
    output logic [XLEN-1:0] RD2,
    input  logic [XLEN-1:0] ResultM,
    output logic [XLEN-1:0] ResultW,
    input  logic [RD_W-1:0] RdM,
    output logic [RD_W-1:0] RdW,
    input  logic [RW_W-1:0] RegWriteM,
    output logic [RW_W-1:0] RegWriteW,
    input  logic            MemToRegM,
    output logic            MemToRegW
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]      off;
    logic [7:0]      we_wide;
    logic [3:0]      lane_we;
    logic [XLEN-1:0] lane_wd;
    logic            misaligned;
    logic            wr_a_ok;
    logic [AW-1:0]   addr_a;
    logic [AW-1:0]   addr_b;
    logic [XLEN-1:0] ram_a_q;
    logic [XLEN-1:0] ram_b_q;

    logic            stall_q;
    logic            clear_q;
    logic            rd_valid_q;
    logic [XLEN-1:0] rd_hold;
    logic [XLEN-1:0] rd_out;

    // Address bits above the RAM depth and the debug byte offset have no
    // meaning here; addresses wrap modulo DEPTH words.
    logic unused_bits;
    assign unused_bits = ^{A[XLEN-1:AW+2], A2[XLEN-1:AW+2], A2[1:0]};

    // Store alignment: shift mask and data into byte lanes. Any mask bit that
    // lands past lane 3 means the access would straddle a word boundary.
    assign off        = A[1:0];
    assign we_wide    = {4'b0000, WE} << off;
    assign lane_we    = we_wide[3:0];
    assign misaligned = |we_wide[7:4];
    assign lane_wd    = WD << {off, 3'b000};
    assign wr_a_ok    = rst_n & en & ~clear & ~misaligned;

    assign addr_a = A[AW+1:2];
    assign addr_b = A2[AW+1:2];

    // One byte-wide memory per lane. Port B is written first and port A last
    // so that port A wins a same-lane, same-word collision. Reads sample the
    // array before this edge's writes land, giving old-data behaviour.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] qa_lane;
        logic [7:0] qb_lane;

        // Lane write (both ports) and registered read (both ports).
        always_ff @(posedge clk) begin
            if (rst_n && WE2[gi]) begin
                mem[addr_b] <= WD2[8*gi +: 8];
            end
            if (wr_a_ok && lane_we[gi]) begin
                mem[addr_a] <= lane_wd[8*gi +: 8];
            end
            qa_lane <= mem[addr_a];
            qb_lane <= mem[addr_b];
        end

        assign ram_a_q[8*gi +: 8] = qa_lane;
        assign ram_b_q[8*gi +: 8] = qb_lane;
    end

    // MEM->WB segment register: capture, flush or hold (stall wins over flush).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            LoadedBytesSelect <= '0;
            StoreMisalignW    <= 1'b0;
            ResultW           <= '0;
            RdW               <= '0;
            RegWriteW         <= '0;
            MemToRegW         <= 1'b0;
        end else if (en) begin
            if (clear) begin
                LoadedBytesSelect <= '0;
                StoreMisalignW    <= 1'b0;
                ResultW           <= '0;
                RdW               <= '0;
                RegWriteW         <= '0;
                MemToRegW         <= 1'b0;
            end else begin
                LoadedBytesSelect <= off;
                StoreMisalignW    <= misaligned;
                ResultW           <= ResultM;
                RdW               <= RdM;
                RegWriteW         <= RegWriteM;
                MemToRegW         <= MemToRegM;
            end
        end
    end

    // Read-path control: remember last edge's stall/flush and keep a copy of
    // the presented RD so a stall freezes it even though the RAM keeps reading.
    // rd_valid_q masks the un-reset RAM output register until the first edge
    // after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q    <= 1'b0;
            clear_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_hold    <= '0;
        end else begin
            stall_q    <= ~en;
            clear_q    <= clear;
            rd_valid_q <= 1'b1;
            rd_hold    <= rd_out;
        end
    end

    // RD selection: hold during stall, zero after a flush, else fresh RAM data.
    always_comb begin
        rd_out = '0;
        if (!rd_valid_q) begin
            rd_out = '0;
        end else if (stall_q) begin
            rd_out = rd_hold;
        end else if (clear_q) begin
            rd_out = '0;
        end else begin
            rd_out = ram_a_q;
        end
    end

    assign RD  = rd_out;
    assign RD2 = ram_b_q;

endmodule
